// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB branch predictor with 2-bit counters and perf counters
module branch_predictor #(
   parameter int IDX_W = 4,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      if_pc,
   output logic             pred_hit,
   output logic             pred_taken,
   output logic [31:0]      pred_npc,
   input  logic             upd_valid,
   input  logic             upd_ifid_wr,
   input  logic [31:0]      upd_pc,
   input  logic [31:0]      upd_pred_npc,
   input  logic [31:0]      upd_actual_npc,
   input  logic [31:0]      upd_target,
   output logic [CNT_W-1:0] stat_branches,
   output logic [CNT_W-1:0] stat_mispred
);

   localparam int DEPTH = 1 << IDX_W;
   localparam int TAG_W = 30 - IDX_W;
   localparam logic [31:0] UNRESOLVED = 32'hFFFF_FFFF;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Table storage, one slot per index
   logic             valid_q  [DEPTH];
   logic [TAG_W-1:0] tag_q    [DEPTH];
   logic [31:0]      target_q [DEPTH];
   logic [1:0]       ctr_q    [DEPTH];

   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             commit;
   logic             taken_res;
   logic             upd_hit;
   logic             mispred;
   logic [1:0]       ctr_cur;
   logic [1:0]       ctr_inc;
   logic [1:0]       ctr_dec;

   // Fetch-side lookup: purely combinational, sees pre-update table contents
   always_comb begin
      if_idx     = if_pc[IDX_W+1:2];
      if_tag     = if_pc[31:IDX_W+2];
      pred_hit   = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
      pred_taken = pred_hit && ctr_q[if_idx][1];
      pred_npc   = pred_taken ? target_q[if_idx] : (if_pc + 32'd4);
   end

   // Resolution decode: a branch trains only on the cycle it actually leaves ID
   always_comb begin
      upd_idx   = upd_pc[IDX_W+1:2];
      upd_tag   = upd_pc[31:IDX_W+2];
      commit    = upd_valid && upd_ifid_wr && (upd_actual_npc != UNRESOLVED);
      // A target equal to the fall-through address is indistinguishable from not taken
      taken_res = (upd_actual_npc == upd_target) && (upd_actual_npc != (upd_pc + 32'd4));
      upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
      mispred   = (upd_pred_npc != upd_actual_npc);
      ctr_cur   = ctr_q[upd_idx];
      ctr_inc   = (ctr_cur == 2'b11) ? 2'b11 : (ctr_cur + 2'b01);
      ctr_dec   = (ctr_cur == 2'b00) ? 2'b00 : (ctr_cur - 2'b01);
   end

   // Table training: strengthen/weaken on hit, allocate only on a taken miss
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
      end else if (commit) begin
         if (upd_hit) begin
            if (taken_res) begin
               ctr_q[upd_idx]    <= ctr_inc;
               target_q[upd_idx] <= upd_target;
            end else begin
               ctr_q[upd_idx]    <= ctr_dec;
            end
         end else if (taken_res) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
            ctr_q[upd_idx]    <= 2'b10;
         end
      end
   end

   // Saturating performance counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_branches <= '0;
         stat_mispred  <= '0;
      end else if (commit) begin
         if (stat_branches != CNT_MAX) begin
            stat_branches <= stat_branches + 1'b1;
         end
         if (mispred && (stat_mispred != CNT_MAX)) begin
            stat_mispred <= stat_mispred + 1'b1;
         end
      end
   end

endmodule
